uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters. It grants one requester at a time, presents that requester's byte to the transmitter, and drives the transmitter start and enable. It watches transmitter busy/done, acknowledges the requester when the frame completes, and forces a transmitter reset if a launch is not accepted in time.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
START_TIMEOUT, 8, max cycles in LAUNCH waiting for tx_busy before abort (>=3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester level request; held until ack
req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i]=1
ack  output  NUM_REQ  one-cycle pulse on the granted index when its frame completes
err  output  1  one-cycle pulse when a launch times out
grant_id  output  clog2(NUM_REQ)  index of current or last grant
active  output  1  high from grant until RELEASE/ABORT completes
tx_en  output  1  transmitter enable; low only in reset and ABORT
tx_start  output  1  transmitter start request
tx_data  output  8  byte to transmitter, registered at grant
tx_busy  input  1  transmitter busy
tx_done  input  1  transmitter one-cycle frame-complete pulse

Behaviour:
- Reset values (all registered outputs): ack=0, err=0, grant_id=NUM_REQ-1 (so index 0 wins first), active=0, tx_en=0, tx_start=0, tx_data=0, state=IDLE, timeout counter=0. tx_en rises on the first cycle after rst drops.
- States: IDLE, LAUNCH, SENDING, RELEASE, ABORT.
- IDLE:
  - If any req bit is set, grant the first set index searching upward from grant_id+1, wrapping modulo NUM_REQ.
  - At that edge, register grant_id, tx_data=req_data[grant], active=1, tx_start=1, counter=0, and go to LAUNCH.
  - With no req, stay in IDLE.
- LAUNCH:
  - tx_start stays 1; counter increments each cycle.
  - When tx_busy=1 is sampled: tx_start=0, go to SENDING.
  - If counter reaches START_TIMEOUT-1 without tx_busy: go to ABORT.
- SENDING:
  - tx_start=0; tx_data is held.
  - When tx_done=1 is sampled: go to RELEASE.
  - tx_busy falling without tx_done has no effect; only tx_done ends the frame.
- RELEASE (one cycle): ack[grant_id]=1, active=1, then go to IDLE with active=0. req is not evaluated in RELEASE.
- ABORT (one cycle): tx_en=0, tx_start=0, err=1, no ack. Then go to IDLE with tx_en=1 and active=0. grant_id still advances, so the aborted requester loses priority but keeps its req.
- Handshake rules:
  - A requester drops req on the edge where it samples ack=1.
  - The arbiter next samples req one edge later in IDLE, so one request never gets two grants.
  - req[i] dropped while i is granted is ignored; the frame completes and ack still pulses.
- Latency:
  - req rising in IDLE → tx_start high the next cycle.
  - tx_done sampled → ack pulse the next cycle → earliest next grant one cycle after that.
- Simultaneous requests are served strictly in round-robin order, one frame each.
- tx_start is never high in SENDING, so the transmitter never re-launches from its stop bit.
- rst mid-frame: all state returns to reset values on the next edge; no ack or err pulse. tx_en=0 during rst also resets the transmitter.
- Unused req bits above NUM_REQ do not exist; grant_id never exceeds NUM_REQ-1.

Test Plan:
1. Reset, then req=4'b0001, data0=8'hA5 → tx_start high 1 cycle after req. tx_data=8'hA5, grant_id=0. tx_start drops on tx_busy. ack=4'b0001 one cycle after tx_done. active low after.
2. req=4'b1111 held, each dropped on its ack → grants in order 0,1,2,3 with tx_data matching each byte. Exactly one ack per index; at least one IDLE cycle between frames.
3. Fairness: req[0] and req[2] re-asserted immediately after every ack → grants alternate 0,2,0,2 across 6 frames.
4. Timeout: transmitter model never raises tx_busy → after 8 LAUNCH cycles, tx_en=0 and err=1 for one cycle, no ack. Then tx_en=1 and the next requester is granted.
5. Reset mid-frame: assert rst during SENDING → next cycle all outputs at reset values, no ack. After release, the pending req is granted starting from index 0.
6. Requester 1 drops req during SENDING → frame still completes and ack[1] pulses. The next grant goes to the next set bit only.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART byte transmitter
// between NUM_REQ requesters. It launches the granted byte, waits for the
// frame to finish, acknowledges the requester, and resets the transmitter
// when a launch is not accepted within START_TIMEOUT cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no frame in flight; pick next requester round-robin
// S_LAUNCH  | tx_start held high, waiting for the transmitter to go busy
// S_SENDING | frame in progress, waiting for tx_done
// S_RELEASE | one-cycle ack pulse to the granted requester
// S_ABORT   | one-cycle transmitter reset (tx_en low) and err pulse
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       tx_en,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SENDING,
    S_RELEASE,
    S_ABORT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [GW-1:0]      r_grant_id, w_grant_nxt, w_pick;
  logic [7:0]         r_tx_data, w_data_nxt;
  logic               r_active, w_active_nxt;
  logic               r_tx_start, w_start_nxt;
  logic               r_tx_en, w_en_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic               r_err, w_err_nxt;

  // First set request strictly after 'last', wrapping. Iterating from the
  // farthest offset down lets the nearest one overwrite the result.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    int idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[GW'(idx)]) pick = GW'(idx);
    end
    return pick;
  endfunction

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant_id;
    w_data_nxt   = r_tx_data;
    w_active_nxt = r_active;
    w_start_nxt  = r_tx_start;
    w_en_nxt     = 1'b1;
    w_ack_nxt    = '0;
    w_err_nxt    = 1'b0;
    w_pick       = rr_pick(req, r_grant_id);

    case (r_state)
      S_IDLE: begin
        w_active_nxt = 1'b0;
        w_start_nxt  = 1'b0;
        if (|req) begin
          w_state_nxt  = S_LAUNCH;
          w_grant_nxt  = w_pick;
          w_active_nxt = 1'b1;
          w_start_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == GW'(i)) w_data_nxt = req_data[8*i +: 8];
          end
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (tx_busy) begin
          w_state_nxt = S_SENDING;
          w_start_nxt = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ABORT;
          w_start_nxt = 1'b0;
          w_en_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
        end
      end
      S_SENDING: begin
        w_start_nxt = 1'b0;
        if (tx_done) begin
          w_state_nxt            = S_RELEASE;
          w_ack_nxt[r_grant_id]  = 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_nxt  = S_IDLE;
        w_active_nxt = 1'b0;
      end
      S_ABORT: begin
        w_state_nxt  = S_IDLE;
        w_active_nxt = 1'b0;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_active_nxt = 1'b0;
        w_start_nxt  = 1'b0;
      end
    endcase
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_grant_id <= GRANT_RST;
      r_tx_data  <= '0;
      r_active   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_en    <= 1'b0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant_id <= w_grant_nxt;
      r_tx_data  <= w_data_nxt;
      r_active   <= w_active_nxt;
      r_tx_start <= w_start_nxt;
      r_tx_en    <= w_en_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign grant_id = r_grant_id;
  assign active   = r_active;
  assign tx_en    = r_tx_en;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: lockstep requester/transmitter models and a
// transaction-level round-robin reference.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   ack;
  logic           err;
  logic [1:0]     grant_id;
  logic           active;
  logic           tx_en;
  logic           tx_start;
  logic [7:0]     tx_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] m_req;
  logic [7:0]   m_byte [N];
  int           m_last;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .grant_id (grant_id),
    .active   (active),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req = m_req;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = m_byte[i];
  endtask

  task automatic set_req(input int i);
    m_byte[i] = 8'($urandom);
    m_req[i]  = 1'b1;
  endtask

  // Round-robin rule: first pending index after the last grant, wrapping.
  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ack"},      ack,      '0);
    check_val({tag, "_err"},      err,      0);
    check_val({tag, "_grant"},    grant_id, N - 1);
    check_val({tag, "_active"},   active,   0);
    check_val({tag, "_tx_en"},    tx_en,    0);
    check_val({tag, "_tx_start"}, tx_start, 0);
    check_val({tag, "_tx_data"},  tx_data,  0);
  endtask

  // One complete grant cycle. Entry: DUT in IDLE, m_req non-empty; the next
  // edge performs the grant. Exit: DUT in IDLE again.
  task automatic run_frame(input bit timeout, input int busy_dly, input int len,
                           input bit drop_mid, input bit reraise);
    int g;
    g = rr_next(m_req, m_last);
    drive();
    step();
    check_val("grant_start",  tx_start, 1);
    check_val("grant_id",     grant_id, g);
    check_val("grant_data",   tx_data,  m_byte[g]);
    check_val("grant_active", active,   1);
    check_val("grant_tx_en",  tx_en,    1);
    check_val("grant_ack",    ack,      '0);
    m_last = g;
    if (timeout) begin
      for (int c = 1; c < TO; c++) begin
        step();
        check_val("launch_start", tx_start, 1);
        check_val("launch_err",   err,      0);
      end
      step();
      check_val("abort_err",    err,      1);
      check_val("abort_tx_en",  tx_en,    0);
      check_val("abort_start",  tx_start, 0);
      check_val("abort_ack",    ack,      '0);
      check_val("abort_active", active,   1);
      step();
      check_val("post_abort_err",    err,    0);
      check_val("post_abort_tx_en",  tx_en,  1);
      check_val("post_abort_active", active, 0);
      check_val("post_abort_ack",    ack,    '0);
      return;
    end
    for (int c = 0; c < busy_dly; c++) begin
      step();
      check_val("launch_wait_start", tx_start, 1);
    end
    tx_busy = 1'b1;
    step();
    check_val("sending_start",  tx_start, 0);
    check_val("sending_active", active,   1);
    check_val("sending_err",    err,      0);
    for (int c = 0; c < len; c++) begin
      if (drop_mid && c == 0) begin
        m_req[g] = 1'b0;
        drive();
      end
      if (c == len - 1 && $urandom_range(0, 1) == 1) tx_busy = 1'b0;
      step();
      check_val("sending_ack",   ack,      '0);
      check_val("sending_start", tx_start, 0);
    end
    tx_done = 1'b1;
    tx_busy = 1'b0;
    step();
    check_val("release_ack",    ack,      N'(1) << g);
    check_val("release_active", active,   1);
    check_val("release_start",  tx_start, 0);
    tx_done  = 1'b0;
    m_req[g] = 1'b0;
    if (reraise) set_req(g);
    drive();
    step();
    check_val("idle_ack",    ack,      '0);
    check_val("idle_active", active,   0);
    check_val("idle_start",  tx_start, 0);
    check_val("idle_tx_en",  tx_en,    1);
  endtask

  initial begin
    int g;
    m_req  = '0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_byte[i] = 8'h00;
    drive();

    // Reset values, then tx_en rising on the first cycle out of reset.
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();
    check_val("first_tx_en",  tx_en,    1);
    check_val("first_start",  tx_start, 0);
    check_val("first_active", active,   0);

    // Single requester with a known byte.
    m_req = 4'b0001;
    m_byte[0] = 8'hA5;
    run_frame(0, 0, 3, 0, 0);

    // All four requesting: served 0,1,2,3.
    for (int i = 0; i < N; i++) set_req(i);
    for (int f = 0; f < 4; f++)
      run_frame(0, $urandom_range(0, 6), $urandom_range(1, 5), 0, 0);

    // Fairness between 0 and 2, each re-asserting after its ack.
    m_req = '0;
    set_req(0);
    set_req(2);
    for (int f = 0; f < 6; f++)
      run_frame(0, $urandom_range(0, 6), $urandom_range(1, 4), 0, 1);

    // Launch timeout, then the next requester is served.
    run_frame(1, 0, 0, 0, 0);
    run_frame(0, 2, 2, 0, 0);
    run_frame(0, 1, 2, 0, 0);

    // Requester drops req while its frame is in flight.
    m_req = '0;
    set_req(1);
    set_req(3);
    run_frame(0, 1, 4, 1, 0);
    run_frame(0, 0, 2, 0, 0);

    // Reset during SENDING.
    m_req = '0;
    set_req(1);
    set_req(2);
    g = rr_next(m_req, m_last);
    drive();
    step();
    check_val("rst_mid_grant", grant_id, g);
    tx_busy = 1'b1;
    step();
    check_val("rst_mid_sending", tx_start, 0);
    step();
    rst = 1'b1;
    step();
    check_reset_vals("rst_mid");
    rst     = 1'b0;
    tx_busy = 1'b0;
    m_last  = N - 1;
    run_frame(0, 1, 2, 0, 0);

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      if (m_req == '0) begin
        int idle;
        idle = $urandom_range(0, 3);
        for (int c = 0; c < idle; c++) begin
          step();
          check_val("rand_idle_start",  tx_start, 0);
          check_val("rand_idle_active", active,   0);
        end
      end
      for (int i = 0; i < N; i++)
        if (!m_req[i] && $urandom_range(0, 2) == 0) set_req(i);
      if (m_req == '0) set_req($urandom_range(0, N - 1));
      run_frame($urandom_range(0, 6) == 0, $urandom_range(0, 6), $urandom_range(1, 5),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
